mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  CPU-side memory bus controller, directly upstream of the 128x8 sync ROM, the 96x8 sync RW RAM and the I/O ports.
//  Accepts one load/store request at a time and drives address/WE/data_in to the memories.
//  Sequences the one-cycle sync read latency, selects read data by region, owns the I/O port registers and acks the CPU.
// PARAMETERS
//  RW_BASE      8'd128  first RW RAM address (ROM is 0..RW_BASE-1)
//  RW_TOP       8'd223  last RW RAM address
//  OUT_PORT_ADR 8'd224  write-only output port register address
//  IN_PORT_ADR  8'd240  read-only input port address
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-high reset
//  cpu_req      in   1  request; sampled only in IDLE; CPU holds it until cpu_ack
//  cpu_we       in   1  1=store, 0=load; sampled with cpu_req
//  cpu_addr     in   8  byte address
//  cpu_wdata    in   8  store data
//  cpu_ack      out  1  one-cycle completion pulse
//  cpu_rdata    out  8  load data; valid while cpu_ack=1, held until next load completes
//  mem_address  out  8  address to ROM / RW RAM (registered)
//  mem_we       out  1  write enable to RW RAM (registered)
//  mem_data_in  out  8  write data to RW RAM (registered)
//  rom_data_out in   8  ROM sync read data
//  rw_data_out  in   8  RW RAM sync read data
//  port_in      in   8  external input port
//  port_out     out  8  output port register
//  bus_fault    out  1  only with MEM_BUS_FAULT_EN; pulses with cpu_ack
// BEHAVIOUR
//  Reset: state IDLE; cpu_ack=0, cpu_rdata=0, mem_address=0, mem_we=0, mem_data_in=0, port_out=0, bus_fault=0.
//  Reset asserted mid-transaction aborts it; no ack is issued; a RAM write already sampled by the RAM stands.
//  FSM: IDLE, ACCESS, READ, ACK.
//  IDLE: cpu_req=1 at edge N -> latch addr/we/wdata into mem_address/mem_data_in; state->ACCESS.
//   In the same edge, mem_we<=cpu_we only if the address is in RW_BASE..RW_TOP, else 0.
//  ACCESS: memory samples at edge N+1; mem_we<=0 at N+1.
//   Store -> ACK.
//   Store to OUT_PORT_ADR writes port_out at N+1.
//   Load -> READ.
//  READ: at edge N+2, cpu_rdata<= the read data for the region, then state->ACK:
//   rom_data_out for addr<RW_BASE; rw_data_out for RW_BASE..RW_TOP; port_in for IN_PORT_ADR; 8'h00 otherwise.
//  ACK: cpu_ack=1 for exactly one cycle; next edge -> IDLE.
//   cpu_req is ignored in ACK; a req still high in IDLE is a new request.
//  Latency, req edge to ack cycle: store 1 cycle after N+1 edge (ack visible after N+1); load after N+2.
//  Stores to ROM or unmapped 224..255 addresses (other than OUT_PORT_ADR) have no side effect but are still acked.
//  Region compares are unsigned 8-bit; no wrap-around: 255 is unmapped I/O.
// CONFIGURATION
//  MEM_BUS_FAULT_EN defined:
//   bus_fault=1 in the ACK cycle on a store to addr<RW_BASE.
//   bus_fault=1 in the ACK cycle on any access to 224..255 other than OUT_PORT_ADR (store) or IN_PORT_ADR (load).
//   bus_fault=0 otherwise.
//  MEM_BUS_FAULT_EN undefined: no bus_fault port; such accesses are silently ignored (loads return 8'h00).
// STRUCTURE
//  Package mem_map_pkg: RW_BASE/RW_TOP/IO base constants.
//  mem_map_pkg also holds the region enum (REG_ROM, REG_RW, REG_OUT, REG_IN, REG_NONE) and the FSM state enum.
//  Sub-module mem_addr_decode: combinational, addr -> region enum.
//  Its output is used both for mem_we gating and for read-mux select.
// TESTING
//  Reset mid-ACCESS of a store to 130 -> state IDLE, no cpu_ack, port_out=0, mem_we=0 next cycle.
//  Store 8'hA5 to 150, then load 150 -> mem_we high one cycle.
//   The store acks after edge N+1; the load acks after N+2 with cpu_rdata=8'hA5.
//  Load 5 with rom_data_out=8'h3C -> cpu_rdata=8'h3C on ack.
//   A store to 5 leaves mem_we=0, is acked, and raises bus_fault if enabled.
//  Store 8'h7E to 224 -> port_out=8'h7E.
//   Load 240 with port_in=8'h11 -> cpu_rdata=8'h11.
//   Load 250 -> 8'h00, plus bus_fault if enabled.
//  cpu_req held high through ACK -> exactly one ack per transaction.
//   A new transaction starts in the following IDLE cycle.
//  Boundaries: loads at 127, 128, 223 and 224 -> ROM, RW, RW and unmapped data respectively.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Package: mem_map_pkg
// Memory map constants, region and FSM state types shared by the CPU-side
// memory bus controller and its address decoder.
//   ROM      : 0 .. RW_BASE-1
//   RW RAM   : RW_BASE .. RW_TOP
//   OUT port : OUT_PORT_ADR (write-only)
//   IN port  : IN_PORT_ADR  (read-only)
//   everything else from 224 up is unmapped I/O space.
// Optional feature macro used by users of this package: MEM_BUS_FAULT_EN.
package mem_map_pkg;

  localparam logic [7:0] RW_BASE      = 8'd128;
  localparam logic [7:0] RW_TOP       = 8'd223;
  localparam logic [7:0] OUT_PORT_ADR = 8'd224;
  localparam logic [7:0] IN_PORT_ADR  = 8'd240;

  typedef enum logic [2:0] {
    REG_ROM,
    REG_RW,
    REG_OUT,
    REG_IN,
    REG_NONE
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    READ,
    ACK
  } state_t;

  // An access faults when it targets something that cannot honour it:
  // stores to ROM or the input port, loads from the output port, and
  // anything at all in the unmapped I/O holes.
  function automatic logic access_faults(input region_t region, input logic we);
    logic f;
    case (region)
      REG_ROM: f = we;
      REG_RW:  f = 1'b0;
      REG_OUT: f = ~we;
      REG_IN:  f = we;
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Module: mem_addr_decode
// Combinational byte-address to memory-region decoder.
// Ports:
//   addr   in  8  byte address
//   region out    region_t of that address
// Compares are unsigned 8-bit with no wrap-around, so 255 is unmapped I/O.
module mem_addr_decode
  import mem_map_pkg::*;
(
  input  logic [7:0] addr,
  output region_t    region
);

  always_comb begin
    region = REG_NONE;
    if (addr < RW_BASE) begin
      region = REG_ROM;
    end else if (addr <= RW_TOP) begin
      region = REG_RW;
    end else if (addr == OUT_PORT_ADR) begin
      region = REG_OUT;
    end else if (addr == IN_PORT_ADR) begin
      region = REG_IN;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Module: mem_bus_ctrl
// CPU-side memory bus controller in front of a 128x8 sync ROM, a 96x8 sync
// RW RAM and the I/O port registers. One load/store is handled at a time.
// Ports:
//   clk, reset (async, active-high)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request; cpu_ack/cpu_rdata response
//   mem_address/mem_we/mem_data_in     registered drive to ROM / RW RAM
//   rom_data_out/rw_data_out           sync read data from ROM / RW RAM
//   port_in/port_out                   external input port / output register
//   bus_fault                          present only with MEM_BUS_FAULT_EN
//   dbg_state                          current FSM state
// Handshake: the request is sampled only in IDLE; the CPU holds cpu_req and
// its request fields stable until cpu_ack. cpu_ack is a single-cycle pulse in
// ACK; cpu_req is ignored during ACK, and a request still high in the
// following IDLE cycle is accepted as a new transaction.
// Configuration macro: MEM_BUS_FAULT_EN adds the bus_fault output.
module mem_bus_ctrl
  import mem_map_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  output logic [7:0] mem_address,
  output logic       mem_we,
  output logic [7:0] mem_data_in,
  input  logic [7:0] rom_data_out,
  input  logic [7:0] rw_data_out,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
`ifdef MEM_BUS_FAULT_EN
  output logic       bus_fault,
`endif
  output state_t     dbg_state
);

  state_t     state_q, state_d;
  region_t    cpu_region;
  region_t    region_q;
  logic       we_q;
  logic [7:0] rd_sel;

  mem_addr_decode u_decode (
    .addr   (cpu_addr),
    .region (cpu_region)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cpu_req) state_d = ACCESS;
      ACCESS:  state_d = we_q ? ACK : READ;
      READ:    state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data mux, selected by the region latched with the request.
  always_comb begin
    rd_sel = 8'h00;
    case (region_q)
      REG_ROM: rd_sel = rom_data_out;
      REG_RW:  rd_sel = rw_data_out;
      REG_IN:  rd_sel = port_in;
      default: rd_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_address <= 8'h00;
      mem_we      <= 1'b0;
      mem_data_in <= 8'h00;
      cpu_rdata   <= 8'h00;
      port_out    <= 8'h00;
      region_q    <= REG_ROM;
      we_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            mem_address <= cpu_addr;
            mem_data_in <= cpu_wdata;
            // Only the RW RAM ever sees a write strobe.
            mem_we      <= cpu_we && (cpu_region == REG_RW);
            region_q    <= cpu_region;
            we_q        <= cpu_we;
          end
        end
        ACCESS: begin
          // The memories sample on this edge; drop the strobe right after.
          mem_we <= 1'b0;
          if (we_q && (region_q == REG_OUT)) port_out <= mem_data_in;
        end
        READ: begin
          cpu_rdata <= rd_sel;
        end
        default: ;
      endcase
    end
  end

  assign cpu_ack   = (state_q == ACK);
  assign dbg_state = state_q;

`ifdef MEM_BUS_FAULT_EN
  logic fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if ((state_q == IDLE) && cpu_req) begin
      fault_q <= access_faults(cpu_region, cpu_we);
    end
  end

  assign bus_fault = fault_q && (state_q == ACK);
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Testbench for mem_bus_ctrl: directed load/store sequence against a
// behavioural sync ROM / RW RAM, with a queue of expected load data.
module tb_mem_bus_ctrl;
  import mem_map_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 1'b0;
  logic       cpu_we = 1'b0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic [7:0] mem_address;
  logic       mem_we;
  logic [7:0] mem_data_in;
  logic [7:0] rom_data_out;
  logic [7:0] rw_data_out;
  logic [7:0] port_in = 8'h00;
  logic [7:0] port_out;
`ifdef MEM_BUS_FAULT_EN
  logic       bus_fault;
`endif
  state_t     dbg_state;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem [0:95] = '{default: 8'h00};
  logic [7:0] ram     [0:95] = '{default: 8'h00};

  mem_bus_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata),
    .mem_address  (mem_address),
    .mem_we       (mem_we),
    .mem_data_in  (mem_data_in),
    .rom_data_out (rom_data_out),
    .rw_data_out  (rw_data_out),
    .port_in      (port_in),
    .port_out     (port_out),
`ifdef MEM_BUS_FAULT_EN
    .bus_fault    (bus_fault),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural memories ----------------
  // ROM content is addr ^ 8'h39 (so address 5 reads 8'h3C). Out-of-range
  // RW reads return 8'hEE so a wrong read-mux choice is visible.
  always @(posedge clk) begin
    rom_data_out <= mem_address ^ 8'h39;
    if (mem_address >= 8'd128 && mem_address <= 8'd223) begin
      rw_data_out <= ram[7'(mem_address - 8'd128)];
      if (mem_we) ram[7'(mem_address - 8'd128)] <= mem_data_in;
    end else begin
      rw_data_out <= 8'hEE;
    end
  end

  // ---------------- model ----------------
  function automatic logic in_rw(input logic [7:0] a);
    return (a >= 8'd128) && (a <= 8'd223);
  endfunction

  function automatic logic [7:0] model_load(input logic [7:0] a);
    if (a < 8'd128)      return a ^ 8'h39;
    if (in_rw(a))        return ref_mem[7'(a - 8'd128)];
    if (a == 8'd240)     return port_in;
    return 8'h00;
  endfunction

`ifdef MEM_BUS_FAULT_EN
  function automatic logic model_fault(input logic we, input logic [7:0] a);
    if (we) return (a < 8'd128) || (a > 8'd224);
    return (a >= 8'd224) && (a != 8'd240);
  endfunction
`endif

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  // ---------------- driver ----------------
  // Starts #1 after a clock edge; returns #1 after the edge that brings
  // the FSM back to IDLE.
  task automatic txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                     input string tag);
    int         lat;
    logic       got;
    logic [7:0] exp_rd;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    if (we && in_rw(addr)) ref_mem[7'(addr - 8'd128)] = wdata;
    if (!we) exp_q.push_back(model_load(addr));
    @(posedge clk); #1;
    check({tag, "/mem_address"}, mem_address, addr);
    check({tag, "/mem_we"}, 8'(mem_we), 8'(we && in_rw(addr)));
    if (we) check({tag, "/mem_data_in"}, mem_data_in, wdata);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check({tag, "/mem_we_drop"}, 8'(mem_we), 8'd0);
      got = cpu_ack;
    end
    check({tag, "/ack_seen"}, 8'(got), 8'd1);
    check({tag, "/ack_latency"}, 8'(lat), we ? 8'd1 : 8'd2);
    if (!we && exp_q.size() > 0) begin
      exp_rd = exp_q.pop_front();
      if (got) check({tag, "/rdata"}, cpu_rdata, exp_rd);
    end
`ifdef MEM_BUS_FAULT_EN
    if (got) check({tag, "/bus_fault"}, 8'(bus_fault), 8'(model_fault(we, addr)));
`endif
    cpu_req = 1'b0;
    @(posedge clk); #1;
    check({tag, "/ack_gone"}, 8'(cpu_ack), 8'd0);
    check({tag, "/state_idle"}, 8'(dbg_state), 8'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         acks;
    logic [7:0] ra, rd, exp_rd;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst/cpu_ack", 8'(cpu_ack), 8'd0);
    check("rst/cpu_rdata", cpu_rdata, 8'h00);
    check("rst/mem_address", mem_address, 8'h00);
    check("rst/mem_we", 8'(mem_we), 8'd0);
    check("rst/mem_data_in", mem_data_in, 8'h00);
    check("rst/port_out", port_out, 8'h00);
    check("rst/state", 8'(dbg_state), 8'(IDLE));
`ifdef MEM_BUS_FAULT_EN
    check("rst/bus_fault", 8'(bus_fault), 8'd0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a store to 130: aborted, never written.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd130; cpu_wdata = 8'h55;
    @(posedge clk); #1;
    check("abort/state_access", 8'(dbg_state), 8'(ACCESS));
    check("abort/mem_we_set", 8'(mem_we), 8'd1);
    reset = 1'b1;
    #1;
    check("abort/state_idle", 8'(dbg_state), 8'(IDLE));
    check("abort/mem_we_clr", 8'(mem_we), 8'd0);
    check("abort/port_out", port_out, 8'h00);
    check("abort/cpu_ack", 8'(cpu_ack), 8'd0);
    cpu_req = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("abort/no_ack", 8'(cpu_ack), 8'd0);
    check("abort/mem_we_next", 8'(mem_we), 8'd0);
    txn(1'b0, 8'd130, 8'h00, "abort_readback");

    // RW store then load
    txn(1'b1, 8'd150, 8'hA5, "st150");
    txn(1'b0, 8'd150, 8'h00, "ld150");

    // ROM load and ROM store
    txn(1'b0, 8'd5, 8'h00, "ld5");
    txn(1'b1, 8'd5, 8'hFF, "st5");

    // I/O ports
    txn(1'b1, 8'd224, 8'h7E, "st224");
    check("port_out_7e", port_out, 8'h7E);
    port_in = 8'h11;
    txn(1'b0, 8'd240, 8'h00, "ld240");
    txn(1'b0, 8'd250, 8'h00, "ld250");
    txn(1'b1, 8'd250, 8'h99, "st250");
    txn(1'b1, 8'd240, 8'h98, "st240");
    check("port_out_kept", port_out, 8'h7E);

    // cpu_req held high through ACK: one ack per transaction, the next
    // transaction begins in the following IDLE cycle.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd150;
    exp_q.push_back(model_load(8'd150));
    exp_q.push_back(model_load(8'd150));
    acks = 0;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      if (cpu_ack) begin
        acks++;
        if (exp_q.size() > 0) begin
          exp_rd = exp_q.pop_front();
          check("hold/rdata", cpu_rdata, exp_rd);
        end
      end
      if (c == 3) check("hold/state_idle", 8'(dbg_state), 8'(IDLE));
      if (c == 4) check("hold/state_access", 8'(dbg_state), 8'(ACCESS));
    end
    cpu_req = 1'b0;
    check("hold/ack_count", 8'(acks), 8'd2);
    @(posedge clk); #1;
    check("hold/ack_gone", 8'(cpu_ack), 8'd0);
    exp_q.delete();

    // Region boundaries
    txn(1'b1, 8'd128, 8'h81, "st128");
    txn(1'b1, 8'd223, 8'hC3, "st223");
    txn(1'b0, 8'd127, 8'h00, "ld127");
    txn(1'b0, 8'd128, 8'h00, "ld128");
    txn(1'b0, 8'd223, 8'h00, "ld223");
    txn(1'b0, 8'd224, 8'h00, "ld224");
    txn(1'b0, 8'd255, 8'h00, "ld255");

    // Random RW traffic
    repeat (6) begin
      ra = 8'($urandom_range(128, 223));
      rd = 8'($urandom_range(0, 255));
      txn(1'b1, ra, rd, "rnd_st");
      txn(1'b0, ra, 8'h00, "rnd_ld");
    end
    port_in = 8'($urandom_range(0, 255));
    txn(1'b0, 8'd240, 8'h00, "rnd_in");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
